// File: rtl/div_pkg.sv
// Shared constants and types for the sequential restoring divider.
//   div_state_t : controller state encoding (IDLE, RUN, DONE)
//   DIV_W       : default operand/result width
//   CNT_W       : width of the step counter at the default width
package div_pkg;

  localparam int DIV_W = 8;
  localparam int CNT_W = $clog2(DIV_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step, purely combinational.
// The {r,q} pair is shifted left by one. The divisor is then trial-subtracted
// from the new partial remainder. The trial result is kept when the borrow
// shows it fits, or when a 1 was shifted out of r; otherwise the old partial
// remainder is restored.
// Ports:
//   r, q       : current partial remainder / quotient-in-progress
//   divisor    : divisor magnitude
//   r_nxt      : partial remainder after this step
//   q_nxt      : quotient after this step (new bit in lsb)
module div_restore_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] r_nxt,
  output logic [WIDTH-1:0] q_nxt
);

  logic [WIDTH-1:0] part;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             keep;

  assign part            = {r[WIDTH-2:0], q[WIDTH-1]};
  assign {borrow, diff}  = {1'b0, part} - {1'b0, divisor};
  // A 1 shifted out of r means the true partial remainder is >= 2^WIDTH,
  // which is always >= divisor. In that case the wrapped diff is the exact
  // result.
  assign keep            = r[WIDTH-1] | ~borrow;
  assign r_nxt           = keep ? diff : part;
  assign q_nxt           = {q[WIDTH-2:0], keep};

endmodule

// File: rtl/div_8bit_seq.sv
// Sequential restoring divider: one trial subtraction per clock.
// A start pulse is accepted only in IDLE. The block then spends WIDTH cycles
// in RUN and one cycle in DONE, during which the done pulse is high.
// Quotient, remainder and div_by_zero are held from done until the next
// accepted start.
// Optional feature macro: DIV_SIGNED_EN adds the signed_op port, which
// selects two's-complement division. Sign fix-up is applied on the
// RUN->DONE update, so latency is unchanged.
// Ports:
//   clk, rst_n           : clock, async active-low reset
//   start                : request (ignored while busy)
//   dividend, divisor    : operands, sampled on accepted start
//   signed_op            : signed mode (DIV_SIGNED_EN only)
//   busy                 : high in RUN and DONE
//   done                 : one-cycle result-valid pulse
//   quotient, remainder  : held results
//   div_by_zero          : divisor was zero, held with results
module div_8bit_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SIGNED_EN
  input  logic             signed_op,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_t       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] r_q, q_q, dvsr_q;
  logic             dz_q;
  logic [WIDTH-1:0] r_nxt, q_nxt;
  logic [WIDTH-1:0] q_fin, r_fin;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .r       (r_q),
    .q       (q_q),
    .divisor (dvsr_q),
    .r_nxt   (r_nxt),
    .q_nxt   (q_nxt)
  );

`ifdef DIV_SIGNED_EN
  logic             neg_a, neg_b;
  logic             neg_q_q, neg_r_q;
  logic [WIDTH-1:0] raw_dvd_q;

  assign neg_a   = signed_op & dividend[WIDTH-1];
  assign neg_b   = signed_op & divisor[WIDTH-1];
  // The most negative value maps to itself. Read as unsigned, that is the
  // correct magnitude.
  assign dvd_mag = neg_a ? (~dividend + 1'b1) : dividend;
  assign dvs_mag = neg_b ? (~divisor + 1'b1) : divisor;

  always_comb begin
    q_fin = q_nxt;
    r_fin = r_nxt;
    if (dz_q) begin
      // The zero-divisor result is all-ones with the raw dividend, in
      // either mode.
      r_fin = raw_dvd_q;
    end else begin
      if (neg_q_q) q_fin = ~q_nxt + 1'b1;
      if (neg_r_q) r_fin = ~r_nxt + 1'b1;
    end
  end
`else
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
  assign q_fin   = q_nxt;
  assign r_fin   = r_nxt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      r_q         <= '0;
      q_q         <= '0;
      dvsr_q      <= '0;
      dz_q        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      raw_dvd_q   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            // q is preloaded with the dividend. Its bits are shifted into r
            // msb-first while quotient bits fill in from the lsb.
            r_q    <= '0;
            q_q    <= dvd_mag;
            dvsr_q <= dvs_mag;
            dz_q   <= (divisor == '0);
            cnt    <= CW'(WIDTH - 1);
            busy   <= 1'b1;
            state  <= RUN;
`ifdef DIV_SIGNED_EN
            neg_q_q   <= neg_a ^ neg_b;
            neg_r_q   <= neg_a;
            raw_dvd_q <= dividend;
`endif
          end
        end
        RUN: begin
          r_q <= r_nxt;
          q_q <= q_nxt;
          if (cnt == '0) begin
            quotient    <= q_fin;
            remainder   <= r_fin;
            div_by_zero <= dz_q;
            done        <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_8bit_seq.sv
// Bench for div_8bit_seq. Issued operations push their expected result into a
// scoreboard queue. A separate monitor pops and compares on every done pulse.
module tb_div_8bit_seq;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dividend = '0, divisor = '0;
  logic       sop = 1'b0;
  logic       busy, done, div_by_zero;
  logic [7:0] quotient, remainder;

  int   total = 0, bad = 0, done_cnt = 0;
  logic prev_done = 1'b0;
  exp_t sb[$];

  always #5 clk = ~clk;

  div_8bit_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
`ifdef DIV_SIGNED_EN
    .signed_op   (sop),
`endif
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: runs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      done_cnt++;
      chk("done_not_back_to_back", {31'd0, prev_done}, 32'd0);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got q=%0h r=%0h expected no done", quotient, remainder);
      end else begin
        e = sb.pop_front();
        chk("quotient", {24'd0, quotient}, {24'd0, e.q});
        chk("remainder", {24'd0, remainder}, {24'd0, e.r});
        chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
        chk("busy_at_done", {31'd0, busy}, 32'd1);
      end
    end
    prev_done = rst_n & done;
  end

  // Issue one operation, then measure latency. The count includes the
  // accepting edge and ends at the edge after which done reads high.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic [7:0] eq, input logic [7:0] er, input logic edz);
    int lat;
    exp_t e;
    e.q = eq; e.r = er; e.dz = edz;
    @(negedge clk);
    dividend = a; divisor = b; sop = s; start = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!done && lat < 40);
    chk("latency", lat, 32'd9);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_quotient"}, {24'd0, quotient}, 32'd0);
    chk({tag, "_remainder"}, {24'd0, remainder}, 32'd0);
    chk({tag, "_dz"}, {31'd0, div_by_zero}, 32'd0);
  endtask

  initial begin
    int d0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_op(8'd100, 8'd7,   1'b0, 8'd14,  8'd2,   1'b0);
    run_op(8'd255, 8'd1,   1'b0, 8'd255, 8'd0,   1'b0);
    run_op(8'd3,   8'd200, 1'b0, 8'd0,   8'd3,   1'b0);
    run_op(8'd5,   8'd0,   1'b0, 8'hFF,  8'd5,   1'b1);
    run_op(8'd200, 8'd16,  1'b0, 8'd12,  8'd8,   1'b0);
    run_op(8'd0,   8'd9,   1'b0, 8'd0,   8'd0,   1'b0);
    run_op(8'd255, 8'd255, 1'b0, 8'd1,   8'd0,   1'b0);

    // Starts during RUN and DONE carry new operands and must be ignored.
    d0 = done_cnt;
    begin
      exp_t e;
      e.q = 8'd14; e.r = 8'd2; e.dz = 1'b0;
      @(negedge clk);
      dividend = 8'd100; divisor = 8'd7; start = 1'b1;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      dividend = 8'd9; divisor = 8'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      dividend = 8'd20; divisor = 8'd4;
      for (int i = 0; i < 20 && !done; i++) @(negedge clk);
      // This negedge falls in DONE; the start is held across the DONE->IDLE edge.
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (15) @(negedge clk);
      chk("ignored_start_done_count", done_cnt - d0, 32'd1);
      chk("ignored_start_quotient", {24'd0, quotient}, 32'd14);
      chk("ignored_start_remainder", {24'd0, remainder}, 32'd2);
    end

    // Reset at RUN cycle 4 abandons the operation without a done pulse.
    d0 = done_cnt;
    @(negedge clk);
    dividend = 8'd200; divisor = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_zero_outputs("post_reset");
    repeat (12) @(negedge clk);
    chk("reset_no_done", done_cnt - d0, 32'd0);
    run_op(8'd50, 8'd5, 1'b0, 8'd10, 8'd0, 1'b0);

`ifdef DIV_SIGNED_EN
    run_op(8'hF9, 8'd2,  1'b1, 8'hFD, 8'hFF, 1'b0);
    run_op(8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b0);
    run_op(8'd7,  8'hFE, 1'b1, 8'hFD, 8'h01, 1'b0);
    run_op(8'hFB, 8'd0,  1'b1, 8'hFF, 8'hFB, 1'b1);
    run_op(8'hF9, 8'd2,  1'b0, 8'd124, 8'd1, 1'b0);
    run_op(8'd100, 8'd7, 1'b0, 8'd14, 8'd2,  1'b0);
`endif

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
